// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: one single-port BRAM shared by display fetch,
// a full-frame clear engine and a valid/ready pixel writer.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned FB_DEPTH = 19200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(FB_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                rd_p1_q, rd_p1_d;
  logic                rd_p2_q, rd_p2_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                wr_err_q, wr_err_d;
  logic                clr_done_q, clr_done_d;
  logic                clr_busy_q, clr_busy_d;
  logic                wr_accept;
  logic                wr_in_range;

  // Writer may only proceed in IDLE when neither display nor a new clear claims the cycle
  assign wr_ready    = reset && (state_q == S_IDLE) && !disp_req && !clr_start;
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = (wr_addr < DEPTH_LIM);

  // Next-state: one RAM op per cycle, display > clear > writer; fetch return pipeline
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_err_d    = 1'b0;
    clr_done_d  = 1'b0;

    if ((state_q == S_IDLE) && clr_start) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      color_d = clr_color;
    end

    if (disp_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = disp_addr;
    end else if (state_q == S_CLEAR) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = cnt_q;
      ram_wdata_d = color_q;
      if (cnt_q == LAST_ADDR) begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        clr_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end else if (wr_accept) begin
      if (wr_in_range) begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = wr_addr;
        ram_wdata_d = wr_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    clr_busy_d   = (state_d == S_CLEAR);
    rd_p1_d      = disp_req;
    rd_p2_d      = rd_p1_q;
    disp_valid_d = rd_p2_q;
    disp_data_d  = rd_p2_q ? ram_rdata : disp_data_q;
  end

  // State and output registers; reset aborts any clear or in-flight fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      color_q      <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_p1_q      <= 1'b0;
      rd_p2_q      <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
      clr_done_q   <= 1'b0;
      clr_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      color_q      <= color_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_p1_q      <= rd_p1_d;
      rd_p2_q      <= rd_p2_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      wr_err_q     <= wr_err_d;
      clr_done_q   <= clr_done_d;
      clr_busy_q   <= clr_busy_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign wr_err     = wr_err_q;
  assign clr_done   = clr_done_q;
  assign clr_busy   = clr_busy_q;

endmodule
